// File: rtl/refill_rd_arbiter.sv
// Round-robin arbiter between the I$ refill and prefetch read requesters onto one AXI shim read port.
// Only one transaction is in flight at a time; returned beats are routed to the owner and protocol errors are flagged.
module refill_rd_arbiter #(
    parameter int AxiAddrWidth = 64,
    parameter int AxiDataWidth = 64,
    parameter int AxiIdWidth   = 4,
    parameter int LineWidth    = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [1:0]                   req_i,
    output logic [1:0]                   gnt_o,
    input  logic [1:0][AxiAddrWidth-1:0] addr_i,
    input  logic [1:0]                   nc_i,
    input  logic [1:0][AxiIdWidth-1:0]   tid_i,
    output logic [1:0]                   rvalid_o,
    output logic                         rlast_o,
    output logic [AxiDataWidth-1:0]      rdata_o,
    output logic [AxiIdWidth-1:0]        rid_o,
    output logic                         shim_req_o,
    output logic [AxiAddrWidth-1:0]      shim_addr_o,
    output logic [7:0]                   shim_blen_o,
    output logic [2:0]                   shim_size_o,
    output logic [AxiIdWidth-1:0]        shim_id_o,
    input  logic                         shim_gnt_i,
    input  logic                         shim_valid_i,
    input  logic                         shim_last_i,
    input  logic [AxiDataWidth-1:0]      shim_data_i,
    input  logic [AxiIdWidth-1:0]        shim_id_i,
    output logic                         err_o
);

    localparam int         Beats    = LineWidth / AxiDataWidth;
    localparam logic [7:0] FullBlen = 8'(Beats - 1);
    localparam logic [2:0] SizeVal  = 3'($clog2(AxiDataWidth / 8));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    owner_q, owner_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]              blen_q, blen_d;
    logic [AxiIdWidth-1:0]   tid_q, tid_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    winner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            blen_q  <= '0;
            tid_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            blen_q  <= blen_d;
            tid_q   <= tid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        blen_d   = blen_q;
        tid_d    = tid_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        gnt_o    = '0;
        rvalid_o = '0;
        rlast_o  = 1'b0;
        winner   = req_i[ptr_q] ? ptr_q : ~ptr_q;

        case (state_q)
            IDLE: begin
                // Any beat arriving with nothing outstanding is dropped and flagged.
                err_d = shim_valid_i;
                if (|req_i) begin
                    gnt_o[winner] = 1'b1;
                    owner_d       = winner;
                    addr_d        = addr_i[winner];
                    blen_d        = nc_i[winner] ? 8'd0 : FullBlen;
                    tid_d         = tid_i[winner];
                    state_d       = ADDR;
                end
            end
            ADDR: begin
                err_d = shim_valid_i;
                if (shim_gnt_i) begin
                    cnt_d   = blen_q;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (shim_valid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    rlast_o           = shim_last_i;
                    err_d             = (shim_id_i != tid_q);
                    // A last beat always closes the transaction, even when it arrives early.
                    if (shim_last_i) begin
                        err_d   = err_d | (cnt_q != 8'd0);
                        state_d = IDLE;
                        ptr_d   = ~owner_q;
                    end else if (cnt_q == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shim_req_o  = (state_q == ADDR);
    assign shim_addr_o = addr_q;
    assign shim_blen_o = blen_q;
    assign shim_size_o = SizeVal;
    assign shim_id_o   = tid_q;
    assign rdata_o     = shim_data_i;
    assign rid_o       = shim_id_i;
    assign err_o       = err_q;

endmodule

// File: tb/tb_refill_rd_arbiter.sv
// Directed plus randomized transaction-level checking of refill_rd_arbiter.
// The model tracks only the round-robin pointer and expected beat count per transaction.
module tb_refill_rd_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       req_i;
    logic [1:0]       gnt_o;
    logic [1:0][63:0] addr_i;
    logic [1:0]       nc_i;
    logic [1:0][3:0]  tid_i;
    logic [1:0]       rvalid_o;
    logic             rlast_o;
    logic [63:0]      rdata_o;
    logic [3:0]       rid_o;
    logic             shim_req_o;
    logic [63:0]      shim_addr_o;
    logic [7:0]       shim_blen_o;
    logic [2:0]       shim_size_o;
    logic [3:0]       shim_id_o;
    logic             shim_gnt_i;
    logic             shim_valid_i;
    logic             shim_last_i;
    logic [63:0]      shim_data_i;
    logic [3:0]       shim_id_i;
    logic             err_o;

    int total = 0;
    int bad   = 0;
    logic ptr_m;

    refill_rd_arbiter #(
        .AxiAddrWidth(64),
        .AxiDataWidth(64),
        .AxiIdWidth  (4),
        .LineWidth   (128)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .nc_i        (nc_i),
        .tid_i       (tid_i),
        .rvalid_o    (rvalid_o),
        .rlast_o     (rlast_o),
        .rdata_o     (rdata_o),
        .rid_o       (rid_o),
        .shim_req_o  (shim_req_o),
        .shim_addr_o (shim_addr_o),
        .shim_blen_o (shim_blen_o),
        .shim_size_o (shim_size_o),
        .shim_id_o   (shim_id_o),
        .shim_gnt_i  (shim_gnt_i),
        .shim_valid_i(shim_valid_i),
        .shim_last_i (shim_last_i),
        .shim_data_i (shim_data_i),
        .shim_id_i   (shim_id_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        req_i        = '0;
        addr_i       = '0;
        nc_i         = '0;
        tid_i        = '0;
        shim_gnt_i   = 1'b0;
        shim_valid_i = 1'b0;
        shim_last_i  = 1'b0;
        shim_data_i  = '0;
        shim_id_i    = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"},   64'(gnt_o), 64'd0);
        checkOutput({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
        checkOutput({tag, "_shimreq"}, 64'(shim_req_o), 64'd0);
        checkOutput({tag, "_err"},   64'(err_o), 64'd0);
        checkOutput({tag, "_rlast"}, 64'(rlast_o), 64'd0);
        checkOutput({tag, "_blen"},  64'(shim_blen_o), 64'd0);
        checkOutput({tag, "_addr"},  shim_addr_o, 64'd0);
        checkOutput({tag, "_id"},    64'(shim_id_o), 64'd0);
    endtask

    task automatic resetDut();
        rst_ni = 1'b0;
        clearInputs();
        #1;
        checkResetOutputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ptr_m  = 1'b0;
    endtask

    // Called one time unit after a rising edge with the DUT idle; returns likewise.
    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] nc,
                                 input logic [63:0] a0, input logic [63:0] a1,
                                 input logic [3:0] t0, input logic [3:0] t1,
                                 input int gdly, input int delta, input int bad_beat,
                                 input bit hold_other, input int rst_beat, input bit stray_ok);
        logic        w;
        logic [7:0]  exp_blen;
        logic [63:0] exp_addr;
        logic [3:0]  exp_tid;
        int          nbeats;
        int          remaining;
        logic        exp_err;
        logic        stray;
        logic [63:0] data;

        w        = req[ptr_m] ? ptr_m : ~ptr_m;
        exp_blen = nc[w] ? 8'd0 : 8'd1;
        exp_addr = w ? a1 : a0;
        exp_tid  = w ? t1 : t0;
        nbeats   = int'(exp_blen) + 1 + delta;
        if (nbeats < 1) nbeats = 1;

        req_i     = req;
        nc_i      = nc;
        addr_i[0] = a0;
        addr_i[1] = a1;
        tid_i[0]  = t0;
        tid_i[1]  = t1;
        #1;
        checkOutput("idle_gnt", 64'(gnt_o), w ? 64'd2 : 64'd1);
        checkOutput("idle_shimreq", 64'(shim_req_o), 64'd0);
        @(posedge clk_i);
        #1;
        req_i = hold_other ? (req & ~(2'b01 << w)) : 2'b00;

        for (int c = 0; c <= gdly; c++) begin
            stray        = stray_ok && (c < gdly) && ($urandom_range(0, 3) == 0);
            shim_gnt_i   = (c == gdly);
            shim_valid_i = stray;
            shim_last_i  = stray;
            #1;
            checkOutput("addr_gnt", 64'(gnt_o), 64'd0);
            checkOutput("addr_req", 64'(shim_req_o), 64'd1);
            checkOutput("addr_addr", shim_addr_o, exp_addr);
            checkOutput("addr_id", 64'(shim_id_o), 64'(exp_tid));
            checkOutput("addr_blen", 64'(shim_blen_o), 64'(exp_blen));
            checkOutput("addr_size", 64'(shim_size_o), 64'd3);
            checkOutput("addr_rvalid", 64'(rvalid_o), 64'd0);
            @(posedge clk_i);
            #1;
            shim_valid_i = 1'b0;
            shim_last_i  = 1'b0;
            shim_gnt_i   = 1'b0;
            checkOutput("addr_err", 64'(err_o), 64'(stray));
        end

        remaining = int'(exp_blen);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                #1;
                checkOutput("gap_rvalid", 64'(rvalid_o), 64'd0);
                @(posedge clk_i);
                #1;
                checkOutput("gap_err", 64'(err_o), 64'd0);
            end
            data         = {$urandom, $urandom};
            shim_valid_i = 1'b1;
            shim_last_i  = (i == nbeats - 1);
            shim_data_i  = data;
            shim_id_i    = (i == bad_beat) ? (exp_tid ^ 4'h1) : exp_tid;
            #1;
            checkOutput("beat_rvalid", 64'(rvalid_o), w ? 64'd2 : 64'd1);
            checkOutput("beat_rlast", 64'(rlast_o), 64'(i == nbeats - 1));
            checkOutput("beat_rdata", rdata_o, data);
            checkOutput("beat_rid", 64'(rid_o), 64'(shim_id_i));
            checkOutput("beat_gnt", 64'(gnt_o), 64'd0);
            exp_err = (i == bad_beat) ||
                      ((i == nbeats - 1) && (remaining != 0)) ||
                      ((i != nbeats - 1) && (remaining == 0));
            if ((i != nbeats - 1) && (remaining != 0)) remaining--;
            @(posedge clk_i);
            #1;
            shim_valid_i = 1'b0;
            shim_last_i  = 1'b0;
            if (i == rst_beat) begin
                resetDut();
                return;
            end
            checkOutput("beat_err", 64'(err_o), 64'(exp_err));
        end
        ptr_m = ~w;
    endtask

    task automatic strayBeat();
        shim_valid_i = 1'b1;
        shim_last_i  = 1'b1;
        shim_id_i    = 4'h5;
        #1;
        checkOutput("stray_rvalid", 64'(rvalid_o), 64'd0);
        checkOutput("stray_rlast", 64'(rlast_o), 64'd0);
        @(posedge clk_i);
        #1;
        shim_valid_i = 1'b0;
        shim_last_i  = 1'b0;
        checkOutput("stray_err", 64'(err_o), 64'd1);
        #1;
        checkOutput("stray_rvalid_after", 64'(rvalid_o), 64'd0);
    endtask

    initial begin
        logic [1:0] rq;
        rst_ni = 1'b0;
        clearInputs();
        @(posedge clk_i);
        #1;
        resetDut();

        $display("[TB] basic two-beat refill");
        applyStimulus(2'b01, 2'b00, 64'h8000_0040, 64'h1234_0000, 4'd3, 4'd7, 1, 0, -1, 1'b0, -1, 1'b0);

        $display("[TB] both requesters, round-robin turnaround");
        resetDut();
        applyStimulus(2'b11, 2'b00, 64'h100, 64'h200, 4'd1, 4'd2, 0, 0, -1, 1'b1, -1, 1'b0);
        applyStimulus(2'b10, 2'b00, 64'h100, 64'h200, 4'd1, 4'd2, 0, 0, -1, 1'b0, -1, 1'b0);

        $display("[TB] non-cacheable single beat, delayed shim grant");
        applyStimulus(2'b10, 2'b10, 64'h300, 64'h340, 4'd4, 4'd9, 0, 0, -1, 1'b0, -1, 1'b0);
        applyStimulus(2'b01, 2'b00, 64'hABC0, 64'h0, 4'd6, 4'd0, 5, 0, -1, 1'b0, -1, 1'b0);

        $display("[TB] early last, stray beat, bad id");
        applyStimulus(2'b10, 2'b00, 64'h0, 64'h5000, 4'd0, 4'd8, 0, -1, -1, 1'b0, -1, 1'b0);
        strayBeat();
        applyStimulus(2'b01, 2'b00, 64'h40, 64'h80, 4'd2, 4'd3, 0, 0, 1, 1'b0, -1, 1'b0);

        $display("[TB] reset mid data");
        applyStimulus(2'b01, 2'b00, 64'h9000, 64'h9100, 4'd5, 4'd6, 0, 0, -1, 1'b0, 0, 1'b0);
        applyStimulus(2'b10, 2'b00, 64'h9000, 64'h9100, 4'd5, 4'd6, 1, 0, -1, 1'b0, -1, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            rq = 2'($urandom_range(1, 3));
            applyStimulus(rq, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                          4'($urandom), 4'($urandom), $urandom_range(0, 4),
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) - 1 : 0,
                          ($urandom_range(0, 7) == 0) ? 0 : -1, 1'b0, -1, 1'b1);
            if ($urandom_range(0, 5) == 0) strayBeat();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
